// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, bit positions,
// FSM state encoding and default widths.
package led_seq_pkg;

    localparam int unsigned DEF_OUT_W   = 18;
    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_DWELL_W = 24;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DWELL    = 3'd2;
    localparam logic [2:0] REG_LENGTH   = 3'd3;
    localparam logic [2:0] REG_PAT_ADDR = 3'd4;
    localparam logic [2:0] REG_PAT_DATA = 3'd5;
    localparam logic [2:0] REG_OUT      = 3'd6;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_STOP   = 1;
    localparam int unsigned CTRL_LOOP   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_INDEX  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/led_seq_timer.sv
// Dwell countdown: load sets the count, enable decrements it, expire pulses
// during the last cycle of a dwell period.
module led_seq_timer
    import led_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               enable,
    input  logic [DWELL_W-1:0] load_value,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A count of N therefore spans exactly N enabled cycles before the next load.
    assign expire = enable && (count == DWELL_W'(1));

endmodule

// File: rtl/led_pattern_seq.sv
// Avalon-MM programmable LED pattern sequencer: steps out_port through a small
// pattern table, holding each entry for a programmable dwell time.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned OUT_W   = DEF_OUT_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [OUT_W-1:0] out_port,
    output logic             irq
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   index;
    logic [IDX_W-1:0]   next_index;
    logic [IDX_W-1:0]   index_inc;
    logic [OUT_W-1:0]   next_out;
    logic               set_done;
    logic               timer_load;
    logic               expire;

    logic               loop_en;
    logic               irq_en;
    logic               done;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_eff;
    logic [IDX_W-1:0]   length;
    logic [IDX_W-1:0]   pat_addr;
    logic [OUT_W-1:0]   pattern [DEPTH];

    logic               wr_en;
    logic               start_req;
    logic               stop_req;
    logic               out_wr;
    logic               unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign start_req = wr_en && (address == REG_CTRL) && writedata[CTRL_START];
    assign stop_req  = wr_en && (address == REG_CTRL) && writedata[CTRL_STOP];
    assign out_wr    = wr_en && (address == REG_OUT);
    assign index_inc = index + 1'b1;
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign irq       = done && irq_en;
    assign unused_wdata = ^writedata;

    led_seq_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .enable     (state == ST_RUN),
        .load_value (dwell_eff),
        .expire     (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_en  <= 1'b0;
            irq_en   <= 1'b0;
            dwell    <= '0;
            length   <= '0;
            pat_addr <= '0;
        end else if (wr_en) begin
            case (address)
                REG_CTRL: begin
                    loop_en <= writedata[CTRL_LOOP];
                    irq_en  <= writedata[CTRL_IRQ_EN];
                end
                REG_DWELL:    dwell    <= writedata[DWELL_W-1:0];
                REG_LENGTH:   length   <= writedata[IDX_W-1:0];
                REG_PAT_ADDR: pat_addr <= writedata[IDX_W-1:0];
                REG_PAT_DATA: pat_addr <= pat_addr + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr_en && (address == REG_PAT_DATA)) begin
            pattern[pat_addr] <= writedata[OUT_W-1:0];
        end
    end

    // Completion and clear can coincide; completion takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else if (set_done) begin
            done <= 1'b1;
        end else if (wr_en && (address == REG_STATUS) && writedata[STAT_DONE]) begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            index    <= '0;
            out_port <= '0;
        end else begin
            state    <= next_state;
            index    <= next_index;
            out_port <= next_out;
        end
    end

    always_comb begin
        next_state = state;
        next_index = index;
        next_out   = out_port;
        set_done   = 1'b0;
        timer_load = 1'b0;

        case (state)
            ST_IDLE: begin
                if (out_wr) begin
                    next_out = writedata[OUT_W-1:0];
                end
            end
            ST_RUN: begin
                if (expire) begin
                    if (index < length) begin
                        next_index = index_inc;
                        next_out   = pattern[index_inc];
                        timer_load = 1'b1;
                    end else if (loop_en) begin
                        next_index = '0;
                        next_out   = pattern[0];
                        timer_load = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                        set_done   = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase

        // Control writes override sequencing; stop beats start when both are set.
        if (stop_req) begin
            next_state = ST_IDLE;
            next_index = index;
            next_out   = out_port;
            set_done   = 1'b0;
            timer_load = 1'b0;
        end else if (start_req) begin
            next_state = ST_RUN;
            next_index = '0;
            next_out   = pattern[0];
            timer_load = 1'b1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_CTRL: begin
                readdata[CTRL_LOOP]   = loop_en;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            REG_STATUS: begin
                readdata[STAT_BUSY]              = (state == ST_RUN);
                readdata[STAT_DONE]              = done;
                readdata[STAT_INDEX +: IDX_W]    = index;
            end
            REG_DWELL:    readdata[DWELL_W-1:0] = dwell;
            REG_LENGTH:   readdata[IDX_W-1:0]   = length;
            REG_PAT_ADDR: readdata[IDX_W-1:0]   = pat_addr;
            REG_OUT:      readdata[OUT_W-1:0]   = out_port;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: stimulus pushes per-cycle expectations
// derived from a sequence-list model; a negedge monitor pops and compares them.
module tb_led_pattern_seq;

    localparam int unsigned OUT_W   = 18;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DWELL_W = 24;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_DWELL  = 3'd2;
    localparam logic [2:0] A_LENGTH = 3'd3;
    localparam logic [2:0] A_PADDR  = 3'd4;
    localparam logic [2:0] A_PDATA  = 3'd5;
    localparam logic [2:0] A_OUT    = 3'd6;

    localparam int K_OUT = 0;
    localparam int K_RD  = 1;
    localparam int K_IRQ = 2;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [2:0]       address    = A_STATUS;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [31:0]      readdata;
    logic [OUT_W-1:0] out_port;
    logic             irq;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } chk_t;

    chk_t sbq[$];
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [OUT_W-1:0] m_pat [DEPTH];
    int               m_dwell;
    int               m_len;
    int               m_paddr;
    bit               m_loop;
    bit               m_irq_en;
    bit               m_done;
    logic [OUT_W-1:0] m_out;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            chk_t        c;
            logic [31:0] act;
            c = sbq.pop_front();
            case (c.kind)
                K_OUT:   act = 32'(out_port);
                K_RD:    act = readdata;
                default: act = {31'b0, irq};
            endcase
            n_tests++;
            if (c.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d only reached at cycle %0d", c.name, c.cyc, cyc);
            end else if ((act & c.mask) != (c.exp & c.mask)) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", c.name, cyc, act & c.mask, c.exp & c.mask);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void expect_at(int kind, logic [31:0] e, logic [31:0] m, string name);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.exp  = e;
        c.mask = m;
        c.name = name;
        sbq.push_back(c);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_pat[i] = '0;
        m_dwell = 0; m_len = 0; m_paddr = 0;
        m_loop = 0; m_irq_en = 0; m_done = 0; m_out = '0;
    endfunction

    function automatic logic [31:0] ctrl_val();
        return {28'b0, m_irq_en, m_loop, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        write_n = 1'b1; address = A_STATUS; writedata = '0;
        case (a)
            A_CTRL:   begin m_loop = d[2]; m_irq_en = d[3]; end
            A_STATUS: if (d[1]) m_done = 0;
            A_DWELL:  m_dwell = int'(d[DWELL_W-1:0]);
            A_LENGTH: m_len = int'(d[2:0]);
            A_PADDR:  m_paddr = int'(d[2:0]);
            A_PDATA:  begin m_pat[m_paddr] = d[OUT_W-1:0]; m_paddr = (m_paddr + 1) % DEPTH; end
            A_OUT:    m_out = d[OUT_W-1:0];
            default: ;
        endcase
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [31:0] e, input logic [31:0] m, input string name);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        expect_at(K_RD, e, m, name);
        tick();
        address = A_STATUS;
    endtask

    // Starts the sequencer and predicts every following cycle from the flat list
    // of (pattern, index) steps the current programming describes.
    task automatic run_seq(input int stop_at, input int out_wr_at, input int w1c_at, input string tag);
        logic [OUT_W-1:0] s_out[$];
        int               s_idx[$];
        int               d, n, k, horizon;
        bit               running, act_stop, act_out, act_w1c, finished_now;
        d = (m_dwell == 0) ? 1 : m_dwell;
        for (int i = 0; i <= m_len; i++)
            for (int r = 0; r < d; r++) begin
                s_out.push_back(m_pat[i]);
                s_idx.push_back(i);
            end
        n = s_out.size();
        if (m_loop) horizon = stop_at + 3;
        else horizon = ((stop_at + 1 > n) ? stop_at + 1 : n) + 3;

        address = A_CTRL; chipselect = 1'b1; write_n = 1'b0; writedata = ctrl_val() | 32'h1;
        tick();
        write_n = 1'b1; address = A_STATUS; writedata = '0;
        running = 1; k = 0;
        for (int j = 0; j < horizon; j++) begin
            act_stop = (j == stop_at);
            act_out  = !act_stop && (j == out_wr_at);
            act_w1c  = !act_stop && !act_out && (j == w1c_at);
            if (running) m_out = s_out[k % n];
            expect_at(K_OUT, 32'(m_out), '1, {tag, "/out"});
            expect_at(K_IRQ, 32'(m_done && m_irq_en), '1, {tag, "/irq"});
            if (act_stop) begin
                address = A_CTRL; write_n = 1'b0; writedata = ctrl_val() | 32'h2;
            end else if (act_out) begin
                address = A_OUT; write_n = 1'b0; writedata = 32'h155;
            end else if (act_w1c) begin
                address = A_STATUS; write_n = 1'b0; writedata = 32'h2;
            end else begin
                expect_at(K_RD, {25'b0, running ? 3'(s_idx[k % n]) : 3'b0, 2'b0, m_done, running},
                          running ? 32'hFFFF_FFFF : 32'hFFFF_FF8F, {tag, "/status"});
            end
            tick();
            write_n = 1'b1; address = A_STATUS; writedata = '0;
            finished_now = 0;
            if (running) begin
                if (act_stop) running = 0;
                else begin
                    k++;
                    if (!m_loop && k == n) begin
                        running = 0; m_done = 1; finished_now = 1;
                    end
                end
            end else if (act_out) begin
                m_out = OUT_W'(32'h155);
            end
            if (act_w1c && !finished_now) m_done = 0;
        end
    endtask

    initial begin
        int n, sa, ow, wc, dw, ln;
        bit lp, ie;
        logic [31:0] v;
        model_reset();
        tick(); tick(); tick();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a); chipselect = 1'b1; write_n = 1'b1;
            expect_at(K_RD, '0, '1, "reset/rd");
            expect_at(K_OUT, '0, '1, "reset/out");
            expect_at(K_IRQ, '0, '1, "reset/irq");
            tick();
        end

        // Three-step one-shot sequence
        reg_write(A_PADDR, 0);
        reg_write(A_PDATA, 32'h1); reg_write(A_PDATA, 32'h2); reg_write(A_PDATA, 32'h4);
        reg_write(A_LENGTH, 2); reg_write(A_DWELL, 3); reg_write(A_CTRL, 0);
        run_seq(-1, -1, -1, "oneshot");

        // Looping, then stopped mid-step after one wrap
        reg_write(A_STATUS, 2); reg_write(A_CTRL, 32'h4);
        check_reg(A_CTRL, ctrl_val(), '1, "ctrl_rd");
        run_seq(13, -1, -1, "loop_stop");

        // Start and stop in the same write leave it idle
        reg_write(A_CTRL, 32'h3);
        expect_at(K_OUT, 32'(m_out), '1, "startstop/out");
        check_reg(A_STATUS, 32'h0, 32'h1, "startstop/busy");

        // Minimum dwell, single entry, interrupt and W1C
        reg_write(A_PADDR, 0); reg_write(A_PDATA, 32'h3FFFF);
        reg_write(A_LENGTH, 0); reg_write(A_DWELL, 0); reg_write(A_CTRL, 32'h8);
        run_seq(-1, -1, -1, "dwell0");
        reg_write(A_STATUS, 2);
        expect_at(K_IRQ, 32'(m_done && m_irq_en), '1, "w1c/irq");
        run_seq(-1, -1, 0, "w1c_race");
        reg_write(A_STATUS, 2);

        // PAT_ADDR wrap and OUT write behaviour
        reg_write(A_PADDR, 7);
        for (int i = 0; i < 9; i++) reg_write(A_PDATA, 32'hFFF0_A000 + 32'(i));
        check_reg(A_PADDR, 32'h0, '1, "wrap/paddr");
        check_reg(A_PDATA, 32'h0, '1, "wrap/pdata_rd");
        reg_write(A_LENGTH, 7); reg_write(A_DWELL, 1); reg_write(A_CTRL, 0);
        run_seq(-1, 2, -1, "wrap_run");
        reg_write(A_OUT, 32'h155);
        expect_at(K_OUT, 32'h155, '1, "idle_out_wr");
        check_reg(A_OUT, 32'h155, '1, "out_rd");
        reg_write(3'd7, 32'hFFFF_FFFF);
        check_reg(3'd7, 32'h0, '1, "unmapped");
        v = $urandom();
        reg_write(A_DWELL, v);
        check_reg(A_DWELL, {8'b0, v[23:0]}, '1, "dwell_rd");

        // Randomized programming
        for (int it = 0; it < 16; it++) begin
            reg_write(A_PADDR, 0);
            for (int e = 0; e < 8; e++) reg_write(A_PDATA, $urandom());
            dw = $urandom_range(0, 3); ln = $urandom_range(0, 7);
            lp = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
            reg_write(A_DWELL, 32'(dw)); reg_write(A_LENGTH, 32'(ln));
            reg_write(A_CTRL, {28'b0, ie, lp, 2'b00});
            if ($urandom_range(0, 1) == 1) reg_write(A_STATUS, 2);
            check_reg(A_LENGTH, 32'(ln), '1, "rand/len_rd");
            check_reg(A_CTRL, ctrl_val(), '1, "rand/ctrl_rd");
            n  = (ln + 1) * ((dw == 0) ? 1 : dw);
            sa = lp ? int'($urandom_range(0, 2 * n + 1))
                    : (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n + 1)) : -1);
            ow = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n + 2)) : -1;
            wc = ($urandom_range(0, 1) == 1) ? n - 1 : -1;
            run_seq(sa, ow, wc, "rand");
        end

        // Asynchronous reset in the middle of a looping run
        reg_write(A_PADDR, 0);
        for (int e = 0; e < 4; e++) reg_write(A_PDATA, 32'h0100 << e);
        reg_write(A_DWELL, 1); reg_write(A_LENGTH, 0); reg_write(A_CTRL, 32'h8);
        run_seq(-1, -1, -1, "pre_arst");
        reg_write(A_DWELL, 2); reg_write(A_LENGTH, 3); reg_write(A_CTRL, 32'hC);
        address = A_CTRL; write_n = 1'b0; writedata = 32'hD;
        tick();
        write_n = 1'b1; address = A_STATUS; writedata = '0;
        tick(); tick();
        expect_at(K_RD, 32'h3, 32'h3, "arst/pre_status");
        expect_at(K_IRQ, 32'h1, '1, "arst/pre_irq");
        tick();
        reset_n = 1'b0;
        model_reset();
        expect_at(K_OUT, '0, '1, "arst/out");
        expect_at(K_IRQ, '0, '1, "arst/irq");
        expect_at(K_RD, '0, '1, "arst/status");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check_reg(A_CTRL, '0, '1, "arst/ctrl");
        check_reg(A_DWELL, '0, '1, "arst/dwell");
        check_reg(A_LENGTH, '0, '1, "arst/len");
        run_seq(-1, -1, -1, "post_arst");

        tick(); tick();
        if (sbq.size() != 0) begin
            n_fail += sbq.size();
            $display("FAIL drain: %0d checks left unmatched, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
